// File: rtl/bsg_mcl_tx_pkg.sv
// Shared types and helpers for the host-to-manycore TX word assembler.
package bsg_mcl_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } tx_state_e;

  localparam int timeout_default_c = 1024;

  function automatic int words_per_pkt(input int packet_width, input int word_width);
    return packet_width / word_width;
  endfunction

endpackage

// File: rtl/bsg_mcl_tx_idle_timer.sv
// Idle timer for a partially filled packet: counts enabled cycles since the
// last clear and pulses expire_o when the count reaches timeout_cycles_p-1.
module bsg_mcl_tx_idle_timer
  import bsg_mcl_tx_pkg::*;
#(
  parameter int timeout_cycles_p = timeout_default_c
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int width_lp = $clog2(timeout_cycles_p);
  localparam logic [width_lp-1:0] last_lp = width_lp'(timeout_cycles_p - 1);

  logic [width_lp-1:0] count_r;

  // A clear in the expiry cycle wins, so a late word still gets accepted.
  assign expire_o = enable_i & ~clear_i & (count_r == last_lp);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      count_r <= '0;
    end else if (clear_i | expire_o) begin
      count_r <= '0;
    end else if (enable_i) begin
      count_r <= count_r + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_mcl_tx_assembler.sv
// Gathers host words into one endpoint packet, gated on out-credits.
// Define BSG_MCL_TX_TIMEOUT_EN to discard stale partial packets after idling.
module bsg_mcl_tx_assembler
  import bsg_mcl_tx_pkg::*;
#(
  parameter int word_width_p      = 32,
  parameter int packet_width_p    = 128,
  parameter int max_out_credits_p = 16,
  parameter int timeout_cycles_p  = timeout_default_c,
  parameter int drop_cnt_width_p  = 16
) (
  input  logic                                                clk_i,
  input  logic                                                reset_i,
  input  logic                                                word_v_i,
  input  logic [word_width_p-1:0]                             word_data_i,
  output logic                                                word_ready_o,
  output logic                                                pkt_v_o,
  output logic [packet_width_p-1:0]                           pkt_data_o,
  input  logic                                                pkt_ready_i,
  input  logic [$clog2(max_out_credits_p+1)-1:0]              out_credits_i,
  input  logic                                                flush_i,
  output logic                                                timeout_o,
  output logic                                                drop_o,
  output logic [$clog2(packet_width_p/word_width_p+1)-1:0]    words_held_o,
  output logic [drop_cnt_width_p-1:0]                         drop_count_o
);

  localparam int els_lp    = words_per_pkt(packet_width_p, word_width_p);
  localparam int held_w_lp = $clog2(els_lp + 1);

  if (timeout_cycles_p < 2 || (packet_width_p % word_width_p) != 0) begin : g_bad_params
    $error("bsg_mcl_tx_assembler: illegal parameter combination");
  end

  tx_state_e                 state_r, state_n;
  logic [packet_width_p-1:0] data_r, data_n;
  logic [held_w_lp-1:0]      held_r, held_n;
  logic                      v_r, v_n;
  logic                      timeout_r, timeout_n;
  logic                      drop_r, drop_n;
  logic [drop_cnt_width_p-1:0] drop_cnt_r;
  logic                      accept, credit_ok, last_word, expire;

  assign word_ready_o = reset_i & (state_r != SEND) & ~flush_i;
  assign accept       = word_v_i & word_ready_o;
  assign credit_ok    = (out_credits_i != '0);
  assign last_word    = (held_r == held_w_lp'(els_lp - 1));

`ifdef BSG_MCL_TX_TIMEOUT_EN
  bsg_mcl_tx_idle_timer #(
    .timeout_cycles_p(timeout_cycles_p)
  ) idle_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (accept | flush_i | (state_r != FILL)),
    .enable_i(state_r == FILL),
    .expire_o(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_n   = state_r;
    data_n    = data_r;
    held_n    = held_r;
    v_n       = v_r;
    timeout_n = 1'b0;
    drop_n    = 1'b0;

    if (accept) begin
      for (int k = 0; k < els_lp; k++) begin
        if (held_r == held_w_lp'(k)) data_n[k*word_width_p +: word_width_p] = word_data_i;
      end
      held_n = held_r + 1'b1;
    end

    unique case (state_r)
      IDLE: begin
        if (accept) begin
          if (last_word) begin
            state_n = SEND;
            v_n     = credit_ok;
          end else begin
            state_n = FILL;
          end
        end
      end
      FILL: begin
        if (flush_i) begin
          state_n = IDLE;
          data_n  = '0;
          held_n  = '0;
          drop_n  = 1'b1;
        end else if (accept) begin
          if (last_word) begin
            state_n = SEND;
            v_n     = credit_ok;
          end
        end else if (expire) begin
          state_n   = IDLE;
          data_n    = '0;
          held_n    = '0;
          drop_n    = 1'b1;
          timeout_n = 1'b1;
        end
      end
      SEND: begin
        // v_r doubles as the commit bit: once raised it ignores credits and flush.
        if (v_r) begin
          if (pkt_ready_i) begin
            state_n = IDLE;
            data_n  = '0;
            held_n  = '0;
            v_n     = 1'b0;
          end
        end else if (flush_i) begin
          state_n = IDLE;
          data_n  = '0;
          held_n  = '0;
          drop_n  = 1'b1;
        end else if (credit_ok) begin
          v_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r    <= IDLE;
      data_r     <= '0;
      held_r     <= '0;
      v_r        <= 1'b0;
      timeout_r  <= 1'b0;
      drop_r     <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      state_r   <= state_n;
      data_r    <= data_n;
      held_r    <= held_n;
      v_r       <= v_n;
      timeout_r <= timeout_n;
      drop_r    <= drop_n;
      if (drop_n && (drop_cnt_r != '1)) drop_cnt_r <= drop_cnt_r + 1'b1;
    end
  end

  assign pkt_v_o      = v_r;
  assign pkt_data_o   = data_r;
  assign timeout_o    = timeout_r;
  assign drop_o       = drop_r;
  assign words_held_o = held_r;
  assign drop_count_o = drop_cnt_r;

endmodule

// File: tb/tb_bsg_mcl_tx_assembler.sv
// Table-driven bench for bsg_mcl_tx_assembler with a packet scoreboard.
// Timeout rows depend on BSG_MCL_TX_TIMEOUT_EN, matching the DUT build.
module tb_bsg_mcl_tx_assembler;

  logic         clk;
  logic         reset_n;
  logic         word_v;
  logic [31:0]  word_data;
  logic         word_ready;
  logic         pkt_v;
  logic [127:0] pkt_data;
  logic         pkt_ready;
  logic [4:0]   credits;
  logic         flush;
  logic         timeout;
  logic         drop;
  logic [2:0]   held;
  logic [15:0]  drop_count;

  bsg_mcl_tx_assembler #(
    .word_width_p     (32),
    .packet_width_p   (128),
    .max_out_credits_p(16),
    .timeout_cycles_p (8),
    .drop_cnt_width_p (16)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_n),
    .word_v_i     (word_v),
    .word_data_i  (word_data),
    .word_ready_o (word_ready),
    .pkt_v_o      (pkt_v),
    .pkt_data_o   (pkt_data),
    .pkt_ready_i  (pkt_ready),
    .out_credits_i(credits),
    .flush_i      (flush),
    .timeout_o    (timeout),
    .drop_o       (drop),
    .words_held_o (held),
    .drop_count_o (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        fl;
    logic [4:0]  cr;
    logic        rdy;
    logic        e_wr;
    logic        e_pv;
    logic [2:0]  e_held;
    logic        e_drop;
    logic        e_to;
    logic        kill_part;
    logic        kill_pkt;
  } vec_t;

  vec_t         cur[$];
  vec_t         tab_a[$];
  vec_t         tab_b[$];
  logic [127:0] sb[$];
  logic [127:0] mbuf;
  int           mn;
  int           exp_dcnt;
  int           passed;
  int           total;
  int           row_idx;
  logic         hold_v;
  logic [127:0] hold_data;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic row(input logic wv, input logic [31:0] wd, input logic fl, input int cr,
                     input logic rdy, input logic e_wr, input logic e_pv, input int e_held,
                     input logic e_drop, input logic e_to,
                     input logic kp = 1'b0, input logic kk = 1'b0);
    vec_t v;
    v.wv = wv; v.wd = wd; v.fl = fl; v.cr = 5'(cr); v.rdy = rdy;
    v.e_wr = e_wr; v.e_pv = e_pv; v.e_held = 3'(e_held);
    v.e_drop = e_drop; v.e_to = e_to; v.kill_part = kp; v.kill_pkt = kk;
    cur.push_back(v);
  endtask

  task automatic wrd(input logic [31:0] d, input int h, input int cr = 16);
    row(1'b1, d, 1'b0, cr, 1'b1, 1'b1, 1'b0, h, 1'b0, 1'b0);
  endtask

  task automatic idle(input int h);
    row(1'b0, 32'h0, 1'b0, 16, 1'b1, 1'b1, 1'b0, h, 1'b0, 1'b0);
  endtask

  task automatic run_rows(input vec_t tab[$]);
    vec_t v;
    foreach (tab[i]) begin
      v = tab[i];
      word_v = v.wv; word_data = v.wd; flush = v.fl; credits = v.cr; pkt_ready = v.rdy;
      @(negedge clk);
      if (v.e_drop) exp_dcnt++;
      chk($sformatf("row%0d_word_ready", row_idx), word_ready, v.e_wr);
      chk($sformatf("row%0d_pkt_v", row_idx), pkt_v, v.e_pv);
      chk($sformatf("row%0d_words_held", row_idx), held, v.e_held);
      chk($sformatf("row%0d_drop", row_idx), drop, v.e_drop);
      chk($sformatf("row%0d_timeout", row_idx), timeout, v.e_to);
      chk($sformatf("row%0d_drop_count", row_idx), drop_count, 16'(exp_dcnt));
      if (v.wv && v.e_wr) begin
        mbuf[mn*32 +: 32] = v.wd;
        mn++;
        if (mn == 4) begin
          sb.push_back(mbuf);
          mbuf = '0;
          mn = 0;
        end
      end
      if (v.kill_part) begin mbuf = '0; mn = 0; end
      if (v.kill_pkt && sb.size() != 0) void'(sb.pop_back());
      row_idx++;
      @(posedge clk); #1;
    end
  endtask

  // Packet scoreboard plus hold-stability check while stalled.
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && pkt_v) chk("pkt_stable", pkt_data, hold_data);
      if (pkt_v && pkt_ready) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL pkt_unexpected: got %0h expected no packet", pkt_data);
        end else begin
          chk("pkt_data", pkt_data, sb.pop_front());
        end
      end
      hold_v    = pkt_v && !pkt_ready;
      hold_data = pkt_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    passed = 0; total = 0; row_idx = 0; mn = 0; mbuf = '0; exp_dcnt = 0;
    hold_v = 1'b0; hold_data = '0;

    // Basic packing
    wrd(32'h11111111, 0); wrd(32'h22222222, 1); wrd(32'h33333333, 2); wrd(32'h44444444, 3);
    row(0, 0, 0, 16, 1, 0, 1, 4, 0, 0);
    idle(0);
    // Credit stall, then commit holds through credit loss and flush
    wrd(32'hA0A0A0A0, 0, 0); wrd(32'hA1A1A1A1, 1, 0); wrd(32'hA2A2A2A2, 2, 0); wrd(32'hA3A3A3A3, 3, 0);
    row(1, 32'hBADBAD00, 0, 0, 1, 0, 0, 4, 0, 0);
    row(0, 0, 0, 0, 1, 0, 0, 4, 0, 0);
    row(0, 0, 0, 1, 0, 0, 0, 4, 0, 0);
    row(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    row(0, 0, 1, 0, 0, 0, 1, 4, 0, 0);
    row(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    row(0, 0, 0, 0, 1, 0, 1, 4, 0, 0);
    idle(0);
    // Flush in IDLE blocks the word and drops nothing
    row(1, 32'hDEADDEAD, 1, 16, 1, 0, 0, 0, 0, 0);
    idle(0);
    // Flush in FILL with 3 held and a word presented
    wrd(32'hB0B0B0B0, 0); wrd(32'hB1B1B1B1, 1); wrd(32'hB2B2B2B2, 2);
    row(1, 32'hBADBAD01, 1, 16, 1, 0, 0, 3, 0, 0, 1'b1);
    row(0, 0, 0, 16, 1, 1, 0, 0, 1, 0);
    idle(0);
    wrd(32'hC0C0C0C0, 0); wrd(32'hC1C1C1C1, 1); wrd(32'hC2C2C2C2, 2); wrd(32'hC3C3C3C3, 3);
    row(0, 0, 0, 16, 1, 0, 1, 4, 0, 0);
    idle(0);
    // Flush in SEND before commit discards the packet
    wrd(32'hD0D0D0D0, 0, 0); wrd(32'hD1D1D1D1, 1, 0); wrd(32'hD2D2D2D2, 2, 0); wrd(32'hD3D3D3D3, 3, 0);
    row(0, 0, 1, 0, 1, 0, 0, 4, 0, 0, 1'b0, 1'b1);
    row(0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    idle(0);
    // Idle partial packet
    wrd(32'hE0E0E0E0, 0); wrd(32'hE1E1E1E1, 1);
`ifdef BSG_MCL_TX_TIMEOUT_EN
    for (int i = 0; i < 8; i++) idle(2);
    row(0, 0, 0, 16, 1, 1, 0, 0, 1, 1, 1'b1);
    idle(0);
    wrd(32'hF0F0F0F0, 0); wrd(32'hF1F1F1F1, 1); wrd(32'hF2F2F2F2, 2); wrd(32'hF3F3F3F3, 3);
    row(0, 0, 0, 16, 1, 0, 1, 4, 0, 0);
    idle(0);
    // Word arriving on the expiry cycle wins
    wrd(32'h90909090, 0); wrd(32'h91919191, 1);
    for (int i = 0; i < 7; i++) idle(2);
    wrd(32'h92929292, 2);
    idle(3);
    idle(3);
    row(0, 0, 1, 16, 1, 0, 0, 3, 0, 0, 1'b1);
    row(0, 0, 0, 16, 1, 1, 0, 0, 1, 0);
`else
    for (int i = 0; i < 40; i++) idle(2);
    row(0, 0, 1, 16, 1, 0, 0, 2, 0, 0, 1'b1);
    row(0, 0, 0, 16, 1, 1, 0, 0, 1, 0);
`endif
    idle(0);
    wrd(32'h70707070, 0); wrd(32'h71717171, 1);
    tab_a = cur;
    cur.delete();
    wrd(32'h80808080, 0); wrd(32'h81818181, 1); wrd(32'h82828282, 2); wrd(32'h83838383, 3);
    row(0, 0, 0, 16, 1, 0, 1, 4, 0, 0);
    idle(0);
    tab_b = cur;
    cur.delete();

    reset_n = 1'b0; word_v = 1'b1; word_data = 32'hFFFFFFFF; flush = 1'b0;
    credits = 5'd16; pkt_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_word_ready", word_ready, 1'b0);
    chk("reset_pkt_v", pkt_v, 1'b0);
    chk("reset_words_held", held, 3'd0);
    chk("reset_drop", drop, 1'b0);
    chk("reset_timeout", timeout, 1'b0);
    chk("reset_drop_count", drop_count, 16'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; word_v = 1'b0;

    run_rows(tab_a);

    // Reset mid-FILL with two words held
    reset_n = 1'b0; word_v = 1'b1; word_data = 32'hBADBAD02;
    @(negedge clk);
    chk("midreset_word_ready", word_ready, 1'b0);
    chk("midreset_held_before", held, 3'd2);
    @(posedge clk); #1;
    reset_n = 1'b1; word_v = 1'b0;
    mbuf = '0; mn = 0; exp_dcnt = 0;
    @(negedge clk);
    chk("postreset_word_ready", word_ready, 1'b1);
    chk("postreset_pkt_v", pkt_v, 1'b0);
    chk("postreset_words_held", held, 3'd0);
    chk("postreset_drop", drop, 1'b0);
    chk("postreset_timeout", timeout, 1'b0);
    chk("postreset_drop_count", drop_count, 16'd0);
    @(posedge clk); #1;

    run_rows(tab_b);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
